// File: rtl/key_input_conditioner_if.sv
// Key event handshake between the button conditioner and the lock FSM.
// The conditioner drives the event side (master), the lock logic consumes it (slave).
interface key_input_conditioner_if;
  logic key_valid;
  logic key_bit;
  logic key_ready;

  modport master (output key_valid, output key_bit, input key_ready);
  modport slave  (input key_valid, input key_bit, output key_ready);
endinterface

// File: rtl/key_input_conditioner.sv
// Button front end for the digital lock: synchronises and debounces the raw
// "zero" and "one" buttons, turns each clean press into a single key event,
// rejects rollover (both buttons), and holds the event in a one-entry
// valid/ready register until the lock logic accepts it.
module key_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic                    clk_100Mhz,
  input  logic                    reset,
  input  logic                    zero,
  input  logic                    one,
  key_input_conditioner_if.master key_if,
  output logic                    conflict,
  output logic                    dropped
);

  typedef enum logic [1:0] {IDLE, HELD_ZERO, HELD_ONE, BOTH} key_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       raw_keys;
  logic [1:0]       sync_meta;
  logic [1:0]       sync_keys;
  logic [1:0]       stb_keys;
  logic [CNT_W-1:0] db_cnt [2];
  logic             stb_zero;
  logic             stb_one;
  key_state_t       state;
  key_state_t       state_next;
  logic             event_gen;
  logic             event_bit;
  logic             conflict_gen;
  logic             transfer;

  assign raw_keys = {one, zero};
  assign stb_zero = stb_keys[0];
  assign stb_one  = stb_keys[1];
  assign transfer = key_if.key_valid & key_if.key_ready;

  // Two-flop synchroniser per button; bit 0 is "zero", bit 1 is "one"
  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) begin
      sync_meta <= '0;
      sync_keys <= '0;
    end else begin
      sync_meta <= raw_keys;
      sync_keys <= sync_meta;
    end
  end

  // Debounce: the stable level follows the synchronised input only after it has disagreed for DEBOUNCE_CYCLES cycles in a row
  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) begin
      stb_keys <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_keys[i] == stb_keys[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          stb_keys[i] <= sync_keys[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Press/hold tracker state register
  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a press is claimed only from IDLE, and only a full release returns there
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (stb_zero && stb_one) begin
          state_next = BOTH;
        end else if (stb_zero) begin
          state_next = HELD_ZERO;
        end else if (stb_one) begin
          state_next = HELD_ONE;
        end
      end
      HELD_ZERO: begin
        if (stb_one) begin
          state_next = BOTH;
        end else if (!stb_zero) begin
          state_next = IDLE;
        end
      end
      HELD_ONE: begin
        if (stb_zero) begin
          state_next = BOTH;
        end else if (!stb_one) begin
          state_next = IDLE;
        end
      end
      BOTH: begin
        if (!stb_zero && !stb_one) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Event and rollover detection, decoded from the state and the debounced levels
  always_comb begin
    event_gen    = 1'b0;
    event_bit    = 1'b0;
    conflict_gen = 1'b0;
    case (state)
      IDLE: begin
        if (stb_zero && stb_one) begin
          conflict_gen = 1'b1;
        end else if (stb_zero) begin
          event_gen = 1'b1;
        end else if (stb_one) begin
          event_gen = 1'b1;
          event_bit = 1'b1;
        end
      end
      HELD_ZERO: conflict_gen = stb_one;
      HELD_ONE:  conflict_gen = stb_zero;
      default:   conflict_gen = 1'b0;
    endcase
  end

  // One-entry holding register with back-to-back reload and dropped/conflict pulses
  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) begin
      key_if.key_valid <= 1'b0;
      key_if.key_bit   <= 1'b0;
      conflict         <= 1'b0;
      dropped          <= 1'b0;
    end else begin
      conflict <= conflict_gen;
      dropped  <= 1'b0;
      if (event_gen) begin
        if (!key_if.key_valid || transfer) begin
          key_if.key_valid <= 1'b1;
          key_if.key_bit   <= event_bit;
        end else begin
          dropped <= 1'b1;
        end
      end else if (transfer) begin
        key_if.key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/key_input_conditioner.md
Name: key_input_conditioner

Overview:
- Front-end stage for the digital lock FSM. It takes the raw, bouncing "zero" and "one" push-buttons and emits one clean key event per physical press.
- Per button: two-flop synchroniser, counter-based debounce, press/hold FSM with rollover rejection.
- Events are presented on a valid/ready handshake, so the downstream lock logic can consume them at its own pace without losing or duplicating presses.

Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles the synchronised input must differ from the debounced level before the level flips (10 ms at 100 MHz); must be >= 2.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk_100Mhz  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- zero  input  1  raw asynchronous "0" button, high = pressed
- one  input  1  raw asynchronous "1" button, high = pressed
- key_ready  input  1  consumer accepts the held event this cycle
- key_valid  output  1  an event is pending
- key_bit  output  1  value of the pending event: 0 = zero button, 1 = one button
- conflict  output  1  one-cycle pulse, both buttons held together (event rejected)
- dropped  output  1  one-cycle pulse, press lost because an event was already pending and not accepted

Behaviour:
- Reset (reset=0, asynchronous), all of the following go to 0: synchroniser flops, debounced levels, counters, key_valid, key_bit, conflict, dropped. The FSM goes to IDLE. Release is sampled on the next clk_100Mhz edge.
- Synchroniser, per button: 2 flops; sync = second flop.
- Debounce, per button, with debounced level stb:
  - sync == stb: counter <= 0.
  - sync != stb and counter == DEBOUNCE_CYCLES-1: stb <= sync, counter <= 0.
  - Otherwise: counter <= counter+1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles leaves stb unchanged.
- FSM, registered, evaluated on the debounced levels (stb_zero, stb_one). States are IDLE, HELD_ZERO, HELD_ONE, BOTH.
  - IDLE: only stb_zero -> HELD_ZERO and generate event bit 0. Only stb_one -> HELD_ONE and generate event bit 1. Both -> BOTH, conflict pulse, no event.
  - HELD_ZERO: stb_one=1 -> BOTH, conflict pulse. stb_zero=0 and stb_one=0 -> IDLE. Otherwise stay.
  - HELD_ONE: mirror of HELD_ZERO.
  - BOTH: stay until both stb=0, then -> IDLE. No events while in BOTH or on release. A press is recognised only from IDLE.
- Latency: counting the first edge that samples the raw button high as edge 1, stb rises at edge DEBOUNCE_CYCLES+2. key_valid and key_bit are visible after edge DEBOUNCE_CYCLES+3.
- Handshake (one-entry holding register):
  - The transfer happens on any edge with key_valid=1 and key_ready=1.
  - key_valid, once high, stays high with key_bit stable until that transfer.
  - key_ready while key_valid=0 has no effect.
  - Event and key_valid=0: load, key_valid<=1.
  - Event and transfer on the same edge: load the new event, key_valid stays 1 (back-to-back allowed).
  - Event, key_valid=1, no transfer: event discarded, old key_bit kept, dropped pulses for 1 cycle.
  - Transfer with no event: key_valid<=0 next cycle. key_bit holds its last value.
- conflict and dropped are registered single-cycle pulses and may coincide only if the FSM rules allow it (they do not: a conflict never generates an event).
- Button release never produces an event. Holding a button indefinitely produces exactly one event.
- Reset mid-debounce or with key_valid=1: the pending event is lost and the counters are cleared. A button still held after reset is debounced afresh and yields one event.

Test Plan (DEBOUNCE_CYCLES=4, key_ready=1 unless noted):
- Clean press: zero rises, held for 20 cycles -> key_valid=1, key_bit=0 after edge 7, high for exactly 1 cycle. Release gives no further event.
- Bounce: one toggles 1,0,1,0 every 2 cycles, then held high -> no event during the bounce, exactly one event with key_bit=1, 7 edges after the final stable rise.
- Rollover: hold zero (event bit 0 accepted), then press one while zero is held -> conflict pulse 1 cycle, no event. Release one only -> still no event. Release both, press one -> event bit 1.
- Backpressure: key_ready=0, press zero then press one -> key_valid=1 with key_bit=0 held, dropped pulses once on the one-press. Raise key_ready -> transfer, key_valid=0 next cycle.
- Back-to-back: key_ready=0, pending zero event. Assert key_ready on the same edge a new one-press event is generated -> key_valid stays 1, key_bit becomes 1, dropped stays 0.
- Async reset: assert reset=0 mid-debounce and while key_valid=1, asynchronously between clock edges -> key_valid, conflict, dropped go to 0 immediately. Release with zero still held -> one event bit 0, 7 edges after release.
